// File: rtl/mdbrot_vga_framebuf_if.sv
// rtl/mdbrot_vga_framebuf_if.sv - 160x120 plot bus from the Mandelbrot engine into the framebuffer
interface mdbrot_vga_framebuf_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output vga_x,
        output vga_y,
        output vga_colour,
        output vga_plot
    );

    modport slave (
        input vga_x,
        input vga_y,
        input vga_colour,
        input vga_plot
    );
endinterface

// File: rtl/mdbrot_vga_framebuf.sv
// rtl/mdbrot_vga_framebuf.sv - 160x120x3 framebuffer, clear FSM, 640x480@60 4x4-replicated scanout
// Optional FB_BORDER_EN: white one-pixel border around the visible area.
module mdbrot_vga_framebuf #(
    parameter int         CLK_DIV      = 2,
    parameter logic [2:0] CLEAR_COLOUR = 3'd0
) (
    input  logic                        clk,
    input  logic                        rst,
    mdbrot_vga_framebuf_if.slave        plot,
    input  logic                        clear,
    output logic                        busy,
    output logic                        frame_start,
    output logic [7:0]                  VGA_R,
    output logic [7:0]                  VGA_G,
    output logic [7:0]                  VGA_B,
    output logic                        VGA_HS,
    output logic                        VGA_VS,
    output logic                        VGA_BLANK_N
);
    localparam int          FB_SIZE   = 19200;
    localparam logic [14:0] LAST_ADDR = 15'd19199;
    localparam logic [9:0]  H_LAST    = 10'd799;
    localparam logic [9:0]  V_LAST    = 10'd524;
    localparam int          DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {IDLE, CLR} state_t;

    state_t          state, state_nxt;
    logic [14:0]     caddr;
    logic [DIV_W-1:0] div_cnt;
    logic            pen;
    logic [9:0]      hcnt, vcnt;

    logic            plot_ok;
    logic [14:0]     plot_addr;
    logic            mem_we;
    logic [14:0]     mem_waddr;
    logic [2:0]      mem_wdata;
    logic [2:0]      mem [0:FB_SIZE-1];

    logic [6:0]      scan_y;
    logic [7:0]      scan_x;
    logic [14:0]     scan_addr;
    logic            scan_vis;
    logic [14:0]     s1_addr;
    logic            s1_hs, s1_vs, s1_vis;
    logic            s2_hs, s2_vs, s2_vis;
    logic [2:0]      rd_data;
`ifdef FB_BORDER_EN
    logic            s1_border, s2_border;
`endif

    assign pen = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt     <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= pen ? '0 : div_cnt + 1'b1;
            frame_start <= pen && (hcnt == 10'd0) && (vcnt == 10'd0);
            if (pen) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

    // y*160 + x as two shifts and an add; y max 127 keeps this inside 15 bits
    assign plot_addr = ({8'd0, plot.vga_y} << 7) + ({8'd0, plot.vga_y} << 5) + {7'd0, plot.vga_x};
    assign plot_ok   = plot.vga_plot && (plot.vga_x < 8'd160) && (plot.vga_y < 7'd120);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            caddr <= '0;
        end else begin
            state <= state_nxt;
            caddr <= (state == IDLE) ? 15'd0 : caddr + 15'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_waddr = plot_addr;
        mem_wdata = plot.vga_colour;
        case (state)
            IDLE: begin
                if (clear) state_nxt = CLR;
                else if (plot_ok) mem_we = 1'b1;
            end
            CLR: begin
                mem_we    = 1'b1;
                mem_waddr = caddr;
                mem_wdata = CLEAR_COLOUR;
                if (caddr == LAST_ADDR) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CLR);

    // Non-blocking read and write in one process give read-first behaviour
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (pen)    rd_data <= mem[s1_addr];
    end

    assign scan_y    = vcnt[8:2];
    assign scan_x    = hcnt[9:2];
    assign scan_vis  = (hcnt < 10'd640) && (vcnt < 10'd480);
    assign scan_addr = ({8'd0, scan_y} << 7) + ({8'd0, scan_y} << 5) + {7'd0, scan_x};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_addr <= '0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_vis  <= 1'b0;
            s2_hs   <= 1'b1;
            s2_vs   <= 1'b1;
            s2_vis  <= 1'b0;
`ifdef FB_BORDER_EN
            s1_border <= 1'b0;
            s2_border <= 1'b0;
`endif
        end else if (pen) begin
            // Blanked positions read address 0 so the RAM is never indexed past its end
            s1_addr <= scan_vis ? scan_addr : 15'd0;
            s1_hs   <= !((hcnt >= 10'd656) && (hcnt <= 10'd751));
            s1_vs   <= !((vcnt >= 10'd490) && (vcnt <= 10'd491));
            s1_vis  <= scan_vis;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
            s2_vis  <= s1_vis;
`ifdef FB_BORDER_EN
            s1_border <= (hcnt == 10'd0) || (hcnt == 10'd639) || (vcnt == 10'd0) || (vcnt == 10'd479);
            s2_border <= s1_border;
`endif
        end
    end

    always_comb begin
        VGA_R = 8'h00;
        VGA_G = 8'h00;
        VGA_B = 8'h00;
        if (s2_vis) begin
`ifdef FB_BORDER_EN
            if (s2_border) begin
                VGA_R = 8'hFF;
                VGA_G = 8'hFF;
                VGA_B = 8'hFF;
            end else begin
                VGA_R = {8{rd_data[2]}};
                VGA_G = {8{rd_data[1]}};
                VGA_B = {8{rd_data[0]}};
            end
`else
            VGA_R = {8{rd_data[2]}};
            VGA_G = {8{rd_data[1]}};
            VGA_B = {8{rd_data[0]}};
`endif
        end
    end

    assign VGA_HS      = s2_hs;
    assign VGA_VS      = s2_vs;
    assign VGA_BLANK_N = s2_vis;
endmodule

// File: tb/tb_mdbrot_vga_framebuf.sv
// tb/tb_mdbrot_vga_framebuf.sv - directed bench for mdbrot_vga_framebuf (CLK_DIV=2)
module tb_mdbrot_vga_framebuf;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       busy, frame_start;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n;

    mdbrot_vga_framebuf_if pif();

    mdbrot_vga_framebuf #(.CLK_DIV(2), .CLEAR_COLOUR(3'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .plot        (pif),
        .clear       (clear),
        .busy        (busy),
        .frame_start (frame_start),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .VGA_HS      (vga_hs),
        .VGA_VS      (vga_vs),
        .VGA_BLANK_N (vga_blank_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt;

    // Posedges since the last reset release; output at edge 2*(p+2) shows raster position p
    always @(posedge clk or negedge rst) begin
        if (!rst) ecnt <= 0;
        else      ecnt <= ecnt + 1;
    end

    typedef struct {
        int          h;
        int          v;
        logic [26:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int h, int v, logic [2:0] col, logic vis, logic hs);
        vec_t r;
        r.h = h;
        r.v = v;
        r.exp = {vis ? {8{col[2]}} : 8'h00, vis ? {8{col[1]}} : 8'h00,
                 vis ? {8{col[0]}} : 8'h00, hs, 1'b1, vis};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic plot_px(input int x, input int y, input int c);
        pif.vga_x      = 8'(x);
        pif.vga_y      = 7'(y);
        pif.vga_colour = 3'(c);
        pif.vga_plot   = 1'b1;
        @(negedge clk);
        pif.vga_plot   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int e_tgt;

        pif.vga_x = '0; pif.vga_y = '0; pif.vga_colour = '0; pif.vga_plot = 1'b0;

        tbl.push_back(mk(  0,  1, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(639,  1, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(640,  1, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(655,  1, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(656,  1, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(751,  1, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(752,  1, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(799,  1, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(656,  2, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(  0,  4, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(  0, 12, 3'd3, 1'b1, 1'b1));
        tbl.push_back(mk(  3, 12, 3'd3, 1'b1, 1'b1));
        tbl.push_back(mk(  4, 12, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk( 19, 12, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk( 20, 12, 3'd5, 1'b1, 1'b1));
        tbl.push_back(mk( 23, 12, 3'd5, 1'b1, 1'b1));
        tbl.push_back(mk( 24, 12, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(160, 12, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(636, 12, 3'd6, 1'b1, 1'b1));
        tbl.push_back(mk(639, 12, 3'd6, 1'b1, 1'b1));
        tbl.push_back(mk(640, 12, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk( 22, 15, 3'd5, 1'b1, 1'b1));
        tbl.push_back(mk( 22, 16, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(156, 24, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(160, 24, 3'd6, 1'b1, 1'b1));
        tbl.push_back(mk(200, 25, 3'd4, 1'b1, 1'b1));
        tbl.push_back(mk(240, 26, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(280, 27, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(320, 27, 3'd0, 1'b1, 1'b1));

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy_fs", {busy, frame_start}, 2'b00);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 24'h0);
        check("rst_hs_vs_blank", {vga_hs, vga_vs, vga_blank_n}, 3'b110);
        rst = 1'b1;

        // Prefill above address 1000 so the full clear is observable later
        plot_px(60, 6, 7);
        plot_px(80, 6, 7);

        // Clear and plot on the same clock: clear wins
        clear = 1'b1;
        pif.vga_x = 8'd1; pif.vga_y = 7'd1; pif.vga_colour = 3'd3; pif.vga_plot = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        pif.vga_plot = 1'b0;
        check("busy_start", busy, 1'b1);

        n = 0;
        while (busy && n < 25000) begin
            n++;
            if (n == 5000) clear = 1'b1;
            if (n == 5001) clear = 1'b0;
            if (n == 6000) begin
                pif.vga_x = 8'd70; pif.vga_y = 7'd6; pif.vga_colour = 3'd7; pif.vga_plot = 1'b1;
            end
            if (n == 6001) pif.vga_plot = 1'b0;
            @(negedge clk);
        end
        check("busy_len", 32'(n), 32'd19200);

        // Data around the 1000 boundary, then reset a clear when caddr reaches 1000
        plot_px(39, 6, 7);
        plot_px(40, 6, 6);
        plot_px(50, 6, 4);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (1000) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midclr_busy", busy, 1'b0);
        check("midclr_hs_vs_blank", {vga_hs, vga_vs, vga_blank_n}, 3'b110);
        check("midclr_rgb", {vga_r, vga_g, vga_b}, 24'h0);
        @(negedge clk);
        rst = 1'b1;

        // frame_start is one clock wide, right after the first pen tick at (0,0)
        @(negedge clk);
        check("fs_edge1", frame_start, 1'b0);
        @(negedge clk);
        check("fs_edge2", frame_start, 1'b1);
        @(negedge clk);
        check("fs_edge3", frame_start, 1'b0);
        check("busy_after_rst", busy, 1'b0);

        plot_px(5, 3, 5);
        plot_px(0, 3, 3);
        plot_px(159, 3, 6);
        plot_px(160, 0, 7);
        plot_px(0, 120, 7);
        plot_px(200, 2, 7);

        for (int i = 0; i < tbl.size(); i++) begin
            e_tgt = 2 * (tbl[i].v * 800 + tbl[i].h + 2);
            n = 0;
            while (ecnt < e_tgt && n < 60000) begin
                n++;
                @(negedge clk);
            end
            if (ecnt != e_tgt) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scan_sync[%0d]: at edge %0d, required edge %0d", i, ecnt, e_tgt);
            end else begin
                check($sformatf("scan[%0d] h=%0d v=%0d", i, tbl[i].h, tbl[i].v),
                      {5'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n},
                      {5'd0, tbl[i].exp});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
